pattern_scan_engine: RTL
========================

# pattern_scan_engine

Hardware accelerator for the "program 3" bit-pattern search, replacing the software loop. On START it reads a PAT_W-bit pattern and an NBYTES-byte string from data memory over a byte-wide port, then computes three counts:

- matches confined to a single byte;
- bytes containing at least one match;
- matches anywhere in the bit stream, crossing byte boundaries.

It writes the counts back to memory and raises DONE. It generalises the fixed 5-bit / 32-byte / fixed-address case in pattern width, string length and memory map, and adds saturation and full-width count outputs.

## Interface
Parameters:
- PAT_W, 5, pattern width in bits, legal range 1..8.
- NBYTES, 32, string length in bytes, at least 1.
- STR_BASE, 128, address of string byte 0.
- PAT_ADDR, 160, address of the pattern byte; the pattern occupies its upper PAT_W bits.
- RES_BASE, 192, result addresses: RES_BASE+0 in-byte count, +1 byte count, +2 stream count.
- ADDR_W, 8, memory address width.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  run request, sampled only in IDLE.
- DONE  out  1  run complete; held until the next accepted START or RESET.
- mem_addr  out  ADDR_W  read/write address.
- mem_rd_data  in  8  read data; the byte at the address presented in the previous cycle.
- mem_we  out  1  write enable.
- mem_wr_data  out  8  write data.
- cnt_byte, cnt_occ, cnt_str  out  CNT_W each  unsaturated counts; valid while DONE=1.

## Operation
- CNT_W = $clog2(8*NBYTES+1).
- Bit order: string byte 0 comes first; within each byte the MSB comes first.
- FSM states: IDLE → RD_PAT → SCAN → WR_B → WR_O → WR_S → FIN.
  - IDLE: mem_we=0. When START=1, clear all counters, clear DONE, and go to RD_PAT.
  - RD_PAT: mem_addr=PAT_ADDR. Go to SCAN with idx=0.
  - SCAN, idx=0..NBYTES:
    - While idx<NBYTES, mem_addr=STR_BASE+idx.
    - At idx=0, latch pat = mem_rd_data[7:8-PAT_W].
    - At idx≥1, process byte b = mem_rd_data, which is string byte idx-1.
    - After idx=NBYTES, go to WR_B.
  - Per processed byte:
    - In-byte windows b[k+PAT_W-1:k] for k=0..8-PAT_W. Each match adds 1 to cnt_byte.
    - If any in-byte window matches, add 1 to cnt_occ.
    - Stream windows cover {tail, b}, where tail holds the last PAT_W-1 stream bits. For the first byte, only the in-byte windows count. For later bytes, the 8 windows that end inside b count. Then tail ← low PAT_W-1 bits of {tail, b}.
    - When PAT_W=1, tail is empty and the stream count equals the in-byte count.
  - WR_B, WR_O, WR_S: mem_we=1, mem_addr=RES_BASE+0/1/2, mem_wr_data = the matching count saturated to 255.
  - FIN: DONE=1, mem_we=0. Go to IDLE with DONE held.
- START while not in IDLE is ignored.
- RESET, in any state including mid-scan: go to IDLE with DONE=0, mem_we=0, mem_addr=0, mem_wr_data=0 and all counts 0. No further memory writes occur from the aborted run.

## Timing
- Take the edge that samples START in IDLE as edge 0.
  - RD_PAT follows edge 0.
  - SCAN occupies the NBYTES+1 cycles after edges 1..NBYTES+1.
  - Result writes occur in the cycles after edges NBYTES+2, NBYTES+3 and NBYTES+4.
  - DONE rises after edge NBYTES+5; this is 37 cycles for the defaults.
- Memory read latency is exactly 1 cycle. Writes take effect on the edge that ends each WR cycle.
- Reset values of all outputs are 0.
- Count outputs update once per SCAN cycle and are stable from WR_B onward.

## Structure
- Package pse_pkg holds:
  - the state enum (state_t);
  - a function computing CNT_W;
  - a sat8() saturation function.
- Sub-module pse_byte_match, combinational, parametrised by PAT_W.
  - Inputs: tail, b, pat, first.
  - Outputs: in-byte match popcount, occupancy bit, stream match popcount.
  - It is instantiated once.
- The top level holds the FSM, idx counter, tail register and count accumulators.

## Test plan
1. Defaults, all bytes 0, pattern 0 → mem[192]=128, mem[193]=32, mem[194]=252, DONE after 37 cycles.
2. Defaults, all bytes 8'h55, pattern 5'b10101 → 64, 32, 126.
3. Random string with software model for PAT_W=5 and PAT_W=3 (pattern 3'b101) → all three memory results and count ports match the model.
4. NBYTES=64, all zeros, pattern 0 → cnt_byte=256, cnt_occ=64, cnt_str=508; mem[192]=255, mem[193]=64, mem[194]=255.
5. RESET asserted at SCAN idx=10 → DONE=0, no writes to 192..194, all counts 0; a subsequent START produces correct results.
6. START re-pulsed during SCAN → ignored; DONE timing and results are identical to a single pulse.

Source files
------------

// File: rtl/pse_pkg.sv
// pse_pkg: shared types and helpers for pattern_scan_engine.
//   state_t   - controller state encoding
//   cnt_width - width of a count that can hold 0..8*nbytes
//   sat8      - clamp a count to the 8-bit memory result range
package pse_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_PAT = 3'd1,
    S_SCAN   = 3'd2,
    S_WR_B   = 3'd3,
    S_WR_O   = 3'd4,
    S_WR_S   = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  function automatic int cnt_width(input int nbytes);
    return $clog2(8 * nbytes + 1);
  endfunction

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/pse_byte_match.sv
// pse_byte_match: combinational match counter for one string byte.
//   tail   in  last PAT_W-1 stream bits before b (ignored when PAT_W=1)
//   b      in  current string byte, MSB first in the stream
//   pat    in  PAT_W-bit search pattern
//   first  in  b is string byte 0 (no preceding stream bits)
//   n_byte out number of windows lying wholly inside b that match
//   occ    out at least one in-byte window matches
//   n_str  out number of stream windows ending inside b that match
module pse_byte_match #(
  parameter int PAT_W = 5,
  localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1
) (
  input  logic [TAIL_W-1:0] tail,
  input  logic [7:0]        b,
  input  logic [PAT_W-1:0]  pat,
  input  logic              first,
  output logic [3:0]        n_byte,
  output logic              occ,
  output logic [3:0]        n_str
);

  localparam int unsigned NWIN = 9 - PAT_W;

  // With PAT_W=1 the tail slot is a dummy bit that no window reaches.
  logic [TAIL_W+7:0] cat;
  assign cat = {tail, b};

  always_comb begin
    n_byte = '0;
    n_str  = '0;
    for (int unsigned k = 0; k < NWIN; k++) begin
      if (b[k +: PAT_W] == pat) n_byte = n_byte + 4'd1;
    end
    for (int unsigned j = 0; j < 8; j++) begin
      if (cat[j +: PAT_W] == pat) n_str = n_str + 4'd1;
    end
    // Byte 0 has no history: windows straddling into tail do not exist.
    if (first) n_str = n_byte;
  end

  assign occ = (n_byte != '0);

endmodule

// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: reads a pattern and an NBYTES string over a byte-wide
// memory port, counts in-byte matches, bytes with a match and stream matches,
// writes the saturated counts to RES_BASE+0/1/2 and raises DONE.
//   CLK, RESET   clock, synchronous active-high reset
//   START        run request (accepted only in IDLE)
//   DONE         run complete, held until next accepted START or RESET
//   mem_addr     read/write address
//   mem_rd_data  read data, 1-cycle latency
//   mem_we       write enable
//   mem_wr_data  write data
//   cnt_byte, cnt_occ, cnt_str  unsaturated counts
module pattern_scan_engine
  import pse_pkg::*;
#(
  parameter int PAT_W    = 5,
  parameter int NBYTES   = 32,
  parameter int STR_BASE = 128,
  parameter int PAT_ADDR = 160,
  parameter int RES_BASE = 192,
  parameter int ADDR_W   = 8,
  localparam int CNT_W   = cnt_width(NBYTES)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              DONE,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_we,
  output logic [7:0]        mem_wr_data,
  output logic [CNT_W-1:0]  cnt_byte,
  output logic [CNT_W-1:0]  cnt_occ,
  output logic [CNT_W-1:0]  cnt_str
);

  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [PAT_W-1:0]  pat;
  logic [TAIL_W-1:0] tail;
  logic [3:0]        n_byte;
  logic [3:0]        n_str;
  logic              occ;

  pse_byte_match #(.PAT_W(PAT_W)) u_match (
    .tail   (tail),
    .b      (mem_rd_data),
    .pat    (pat),
    .first  (idx == IDX_W'(1)),
    .n_byte (n_byte),
    .occ    (occ),
    .n_str  (n_str)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      idx      <= '0;
      pat      <= '0;
      tail     <= '0;
      DONE     <= 1'b0;
      cnt_byte <= '0;
      cnt_occ  <= '0;
      cnt_str  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            cnt_byte <= '0;
            cnt_occ  <= '0;
            cnt_str  <= '0;
            DONE     <= 1'b0;
            state    <= S_RD_PAT;
          end
        end
        S_RD_PAT: begin
          idx   <= '0;
          state <= S_SCAN;
        end
        S_SCAN: begin
          // Read data lags the address by one cycle: idx=0 sees the pattern,
          // idx=n sees string byte n-1.
          if (idx == '0) begin
            pat <= mem_rd_data[7 -: PAT_W];
          end else begin
            cnt_byte <= cnt_byte + CNT_W'(n_byte);
            cnt_occ  <= cnt_occ + CNT_W'(occ);
            cnt_str  <= cnt_str + CNT_W'(n_str);
            tail     <= mem_rd_data[TAIL_W-1:0];
          end
          if (idx == IDX_W'(NBYTES)) state <= S_WR_B;
          else                       idx   <= idx + IDX_W'(1);
        end
        S_WR_B: state <= S_WR_O;
        S_WR_O: state <= S_WR_S;
        S_WR_S: begin
          DONE  <= 1'b1;
          state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    case (state)
      S_RD_PAT: mem_addr = ADDR_W'(PAT_ADDR);
      S_SCAN: begin
        if (idx < IDX_W'(NBYTES)) mem_addr = ADDR_W'(STR_BASE) + ADDR_W'(idx);
      end
      S_WR_B: begin
        mem_we      = 1'b1;
        mem_addr    = ADDR_W'(RES_BASE);
        mem_wr_data = sat8(32'(cnt_byte));
      end
      S_WR_O: begin
        mem_we      = 1'b1;
        mem_addr    = ADDR_W'(RES_BASE + 1);
        mem_wr_data = sat8(32'(cnt_occ));
      end
      S_WR_S: begin
        mem_we      = 1'b1;
        mem_addr    = ADDR_W'(RES_BASE + 2);
        mem_wr_data = sat8(32'(cnt_str));
      end
      default: ;
    endcase
  end

endmodule
